rtc_timekeeper: RTL and testbench
=================================

Name: rtc_timekeeper

Overview:
Parametrised real-time clock that replaces the fixed-rate clock block. It derives a 1 Hz tick from the system clock through a prescaler of CLK_HZ cycles, and keeps hours, minutes and seconds internally in 24 h form. It supports a set mode with edge-detected minute and hour buttons, a 12/24 h display mode and a one-shot alarm with a timeout. It sits between the board clock and reset and the seven-segment display driver.

Parameters:
CLK_HZ, 50_000_000, system clock cycles per second (minimum 2); the prescaler width is $clog2(CLK_HZ).
ALARM_SECS, 60, number of 1 Hz ticks the alarm output stays high (minimum 1, maximum 255).

Ports:
clk  input  1  system clock, all state updates on its rising edge
rst  input  1  asynchronous active-low reset
run_en  input  1  1 = RUN (time advances), 0 = SET (time frozen, buttons active)
set_min  input  1  minute button, synchronous level; rising edge detected internally
set_hr  input  1  hour button, synchronous level; rising edge detected internally
mode12  input  1  1 = 12 h display format, 0 = 24 h display format
alarm_en  input  1  alarm arm; low clears a ringing alarm
alarm_hr  input  5  alarm hour, 24 h form, 0-23
alarm_min  input  6  alarm minute, 0-59
alarm_ack  input  1  level; clears a ringing alarm
sec  output  6  seconds, 0-59
min  output  6  minutes, 0-59
hr  output  5  hours; 0-23 in 24 h mode, 1-12 in 12 h mode
pm  output  1  1 when the internal hour is 12 or later, valid in both modes
tick  output  1  one-cycle pulse, coincident with each RUN-mode seconds update
alarm  output  1  alarm ringing

Behaviour:
- Reset (rst low, asynchronous):
  - internal time 00:00:00, prescaler 0, state SET, alarm FSM A_IDLE.
  - edge-detect registers 0; tick 0; alarm 0; pm 0.
  - hr reads 0 when mode12=0, 12 when mode12=1.
- Main FSM, states SET and RUN; the state register loads run_en every cycle.
- SET → RUN transition:
  - the prescaler restarts at 0;
  - the first tick occurs CLK_HZ cycles after the state becomes RUN.
- RUN:
  - the prescaler counts 0..CLK_HZ-1 and wraps to 0.
  - In the cycle where the prescaler equals CLK_HZ-1, the next edge advances the time by 1 s and registers tick=1 for exactly one cycle, aligned with the new time value.
  - Carry chain: 59 s → 0 s with min+1; 59 min → 0 min with hr+1; 23:59:59 → 00:00:00.
  - set_min and set_hr edges are ignored, but the edge-detect registers keep sampling, so a button held across RUN → SET gives no spurious increment.
- RUN → SET transition: sec is forced to 0 on the first SET cycle; the prescaler is held at 0 throughout SET; tick stays 0.
- SET:
  - each set_min rising edge (current 1, previous 0) gives min = (min+1) mod 60, with no carry into hr.
  - each set_hr rising edge gives hr = (hr+1) mod 24.
  - simultaneous edges increment both fields in the same cycle.
  - a held button increments only once.
- Display mapping (combinational from registered internal hour h):
  - mode12=0: hr = h.
  - mode12=1: hr = 12 if h is 0; h if 1 ≤ h ≤ 12; h-12 if h ≥ 13.
  - pm = (h ≥ 12) in both modes.
- Alarm FSM, states A_IDLE and A_RING:
  - A_IDLE → A_RING on a RUN seconds update whose new value is alarm_hr:alarm_min:00, provided alarm_en=1. alarm rises in the same cycle as tick.
  - Out-of-range alarm_hr or alarm_min never matches.
  - Setting the time to the alarm value in SET does not trigger the alarm.
  - In A_RING, an 8-bit counter counts ticks. The FSM returns to A_IDLE, with alarm low the next cycle, when the count reaches ALARM_SECS, or when alarm_ack=1, or when alarm_en=0.
  - If ack and a match occur in the same cycle, ack wins and the FSM stays in A_IDLE.
  - Entering SET while ringing leaves the alarm ringing; only ack, disarm or reset clears it.
- Reset mid-operation: everything returns to the reset values immediately. No tick or alarm pulse is generated when reset releases.

Test Plan:
- Reset and prescale (CLK_HZ=4, mode12=0): release rst with run_en=1 → tick on cycles 4, 8, 12 after RUN entry; sec steps 0→1→2; tick width is 1 cycle.
- Rollover: set 23:59, run 60 s → one tick shows 23:59:59, the next shows 00:00:00 with pm=0.
- SET mode: run to 00:00:07, drop run_en → sec=0. Pulse set_min 61 times → min=1, hr unchanged. Hold set_hr high 10 cycles → hr+1 once. Pulse set_min and set_hr in the same cycle → both increment.
- 12 h display: internal hours 0, 12, 13, 23 with mode12=1 → hr shows 12, 12, 1, 11 and pm shows 0, 1, 1, 1. Toggling mode12 changes no internal state.
- Alarm (ALARM_SECS=3): alarm 07:30 with en=1, time runs through 07:30:00 → alarm rises with that tick and falls after the 3rd subsequent tick. Repeat with alarm_ack asserted at 07:30:01 → alarm falls the next cycle. With alarm_en=0 → no alarm.
- Reset mid-run: assert rst at 12:34:56 with the prescaler mid-count → immediate 00:00:00, tick=0, alarm=0, state SET, hr=12 when mode12=1.

Source files
------------

// File: rtl/rtc_timekeeper.sv
// rtc_timekeeper: 24 h real-time clock with prescaler, button set mode,
// 12/24 h display mapping and a one-shot alarm that times out.
module rtc_timekeeper #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int ALARM_SECS = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run_en,
    input  logic       set_min,
    input  logic       set_hr,
    input  logic       mode12,
    input  logic       alarm_en,
    input  logic [4:0] alarm_hr,
    input  logic [5:0] alarm_min,
    input  logic       alarm_ack,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hr,
    output logic       pm,
    output logic       tick,
    output logic       alarm
);
    localparam int PW = $clog2(CLK_HZ);
    localparam logic [PW-1:0] PMAX = PW'(CLK_HZ - 1);

    typedef enum logic {SET, RUN} state_t;
    typedef enum logic {A_IDLE, A_RING} astate_t;

    state_t        state;
    astate_t       astate;
    logic [PW-1:0] pre;
    logic [4:0]    h;
    logic [7:0]    cnt;
    logic          min_q, hr_q;
    logic          adv, step, min_edge, hr_edge, match;
    logic [5:0]    nsec, nmin;
    logic [4:0]    nhr;

    assign adv      = (state == RUN) && run_en;
    assign step     = adv && (pre == PMAX);
    assign min_edge = set_min && !min_q && (state == SET);
    assign hr_edge  = set_hr && !hr_q && (state == SET);
    assign nsec     = (sec == 6'd59) ? 6'd0 : sec + 6'd1;
    assign nmin     = (sec != 6'd59) ? min : (min == 6'd59) ? 6'd0 : min + 6'd1;
    assign nhr      = (sec != 6'd59 || min != 6'd59) ? h : (h == 5'd23) ? 5'd0 : h + 5'd1;
    // Out-of-range alarm settings can never equal a legal next time, so no range check is needed.
    assign match    = step && alarm_en && !alarm_ack && nsec == 6'd0 &&
                      nmin == alarm_min && nhr == alarm_hr;
    assign hr       = !mode12 ? h : (h == 5'd0) ? 5'd12 : (h > 5'd12) ? h - 5'd12 : h;
    assign pm       = h >= 5'd12;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= SET;
            astate <= A_IDLE;
            pre    <= '0;
            sec    <= '0;
            min    <= '0;
            h      <= '0;
            cnt    <= '0;
            min_q  <= 1'b0;
            hr_q   <= 1'b0;
            tick   <= 1'b0;
            alarm  <= 1'b0;
        end else begin
            state <= run_en ? RUN : SET;
            min_q <= set_min;
            hr_q  <= set_hr;
            pre   <= (!adv || pre == PMAX) ? '0 : pre + 1'b1;
            tick  <= step;
            if (step) begin
                sec <= nsec;
                min <= nmin;
                h   <= nhr;
            end else begin
                if (!run_en) sec <= '0;
                if (min_edge) min <= (min == 6'd59) ? 6'd0 : min + 6'd1;
                if (hr_edge) h <= (h == 5'd23) ? 5'd0 : h + 5'd1;
            end
            if (astate == A_IDLE) begin
                if (match) begin
                    astate <= A_RING;
                    alarm  <= 1'b1;
                    cnt    <= '0;
                end
            end else if (alarm_ack || !alarm_en || cnt == 8'(ALARM_SECS)) begin
                astate <= A_IDLE;
                alarm  <= 1'b0;
            end else if (step) begin
                cnt <= cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_rtc_timekeeper.sv
// tb_rtc_timekeeper: scoreboard bench; every expected tick value is queued
// from a software time model and popped when the DUT pulses tick.
module tb_rtc_timekeeper;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run_en = 1'b0, set_min = 1'b0, set_hr = 1'b0, mode12 = 1'b1;
    logic       alarm_en = 1'b0, alarm_ack = 1'b0;
    logic [4:0] alarm_hr = 5'd0;
    logic [5:0] alarm_min = 6'd0;
    logic [5:0] sec, min;
    logic [4:0] hr;
    logic       pm, tick, alarm;

    typedef struct {int s; int m; int h; int p; int a;} rec_t;
    rec_t q[$];
    rec_t e;
    int   n_cmp = 0, n_bad = 0;
    int   ms = 0, mm = 0, mh = 0;
    logic prev_tick = 1'b0;

    rtc_timekeeper #(.CLK_HZ(4), .ALARM_SECS(3)) dut (
        .clk(clk), .rst(rst), .run_en(run_en), .set_min(set_min), .set_hr(set_hr),
        .mode12(mode12), .alarm_en(alarm_en), .alarm_hr(alarm_hr), .alarm_min(alarm_min),
        .alarm_ack(alarm_ack), .sec(sec), .min(min), .hr(hr), .pm(pm), .tick(tick),
        .alarm(alarm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int disp(input int hh, input logic m12);
        return !m12 ? hh : (hh == 0) ? 12 : (hh > 12) ? hh - 12 : hh;
    endfunction

    task automatic push_tick(input int al);
        ms++;
        if (ms == 60) begin ms = 0; mm++; end
        if (mm == 60) begin mm = 0; mh++; end
        if (mh == 24) mh = 0;
        q.push_back('{ms, mm, disp(mh, mode12), int'(mh >= 12), al});
    endtask

    task automatic pulses(input int nm, input int nh);
        for (int i = 0; i < ((nm > nh) ? nm : nh); i++) begin
            set_min = (i < nm);
            set_hr  = (i < nh);
            @(negedge clk);
            set_min = 1'b0;
            set_hr  = 1'b0;
            @(negedge clk);
        end
        mm = (mm + nm) % 60;
        mh = (mh + nh) % 24;
    endtask

    task automatic drain(input int budget);
        int b = 0;
        while (q.size() != 0 && b < budget) begin
            @(posedge clk);
            b++;
        end
        chk("drain", q.size(), 0);
    endtask

    task automatic stop_run();
        run_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        ms = 0;
        chk("set_sec0", int'(sec), 0);
    endtask

    always @(negedge clk) begin
        if (rst && tick) begin
            chk("tick_w", int'(prev_tick), 0);
            if (q.size() == 0) chk("tick_unexp", int'(tick), 0);
            else begin
                e = q.pop_front();
                chk("t_sec", int'(sec), e.s);
                chk("t_min", int'(min), e.m);
                chk("t_hr", int'(hr), e.h);
                chk("t_pm", int'(pm), e.p);
                chk("t_alarm", int'(alarm), e.a);
            end
        end
        prev_tick <= tick;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_sec", int'(sec), 0);
        chk("rst_min", int'(min), 0);
        chk("rst_hr12", int'(hr), 12);
        chk("rst_pm", int'(pm), 0);
        chk("rst_tick", int'(tick), 0);
        chk("rst_alarm", int'(alarm), 0);
        mode12 = 1'b0;
        #1 chk("rst_hr24", int'(hr), 0);
        for (int i = 0; i < 3; i++) push_tick(0);
        run_en = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            chk("tick_cyc", int'(tick), int'(k == 5 || k == 9 || k == 13));
        end
        for (int i = 0; i < 4; i++) push_tick(0);
        drain(100);
        @(negedge clk);
        stop_run();
        chk("set_min_keep", int'(min), 0);

        pulses(61, 0);
        chk("btn_min", int'(min), 1);
        chk("btn_min_hr", int'(hr), 0);
        set_hr = 1'b1;
        repeat (10) @(negedge clk);
        set_hr = 1'b0;
        @(negedge clk);
        mh = 1;
        chk("btn_hold", int'(hr), 1);
        pulses(1, 1);
        chk("btn_both_min", int'(min), 2);
        chk("btn_both_hr", int'(hr), 2);

        mode12 = 1'b1;
        pulses(0, 10);
        chk("h12_hr", int'(hr), 12);
        chk("h12_pm", int'(pm), 1);
        pulses(0, 1);
        chk("h13_hr", int'(hr), 1);
        chk("h13_pm", int'(pm), 1);
        pulses(0, 10);
        chk("h23_hr", int'(hr), 11);
        chk("h23_pm", int'(pm), 1);
        pulses(0, 1);
        chk("h0_hr", int'(hr), 12);
        chk("h0_pm", int'(pm), 0);
        mode12 = 1'b0;
        #1;
        chk("h0_hr24", int'(hr), 0);
        chk("mode_min", int'(min), 2);
        @(negedge clk);

        pulses(57, 23);
        chk("roll_pre_hr", int'(hr), 23);
        chk("roll_pre_min", int'(min), 59);
        run_en = 1'b1;
        for (int i = 0; i < 60; i++) push_tick(0);
        drain(400);
        @(negedge clk);
        stop_run();

        alarm_hr  = 5'd7;
        alarm_min = 6'd30;
        alarm_en  = 1'b1;
        pulses(29, 7);
        run_en = 1'b1;
        for (int i = 0; i < 63; i++) push_tick(int'(i >= 59));
        drain(400);
        @(negedge clk);
        chk("alarm_fall", int'(alarm), 0);
        stop_run();

        pulses(59, 0);
        run_en = 1'b1;
        for (int i = 0; i < 61; i++) push_tick(int'(i >= 59));
        drain(400);
        @(negedge clk);
        alarm_ack = 1'b1;
        chk("ack_before", int'(alarm), 1);
        @(negedge clk);
        chk("ack_after", int'(alarm), 0);
        alarm_ack = 1'b0;
        stop_run();

        alarm_en = 1'b0;
        pulses(59, 0);
        run_en = 1'b1;
        for (int i = 0; i < 61; i++) push_tick(0);
        drain(400);
        @(negedge clk);
        stop_run();

        alarm_en = 1'b1;
        pulses(59, 0);
        pulses(1, 0);
        chk("set_match_min", int'(min), 30);
        chk("set_noalarm", int'(alarm), 0);

        alarm_en = 1'b0;
        pulses(4, 5);
        run_en = 1'b1;
        for (int i = 0; i < 56; i++) push_tick(0);
        drain(300);
        @(negedge clk);
        mode12 = 1'b1;
        rst = 1'b0;
        #1;
        chk("mid_sec", int'(sec), 0);
        chk("mid_min", int'(min), 0);
        chk("mid_hr", int'(hr), 12);
        chk("mid_pm", int'(pm), 0);
        chk("mid_tick", int'(tick), 0);
        chk("mid_alarm", int'(alarm), 0);
        ms = 0; mm = 0; mh = 0;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("rel_tick", int'(tick), 0);
        end
        stop_run();
        chk("final_queue", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
